// File: rtl/udp_parser_pkg.sv
// Shared types and protocol constants for the UDP receive parser.
package udp_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ETH     = 3'd1,
        ST_IP      = 3'd2,
        ST_UDP     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_DRAIN   = 3'd5
    } parser_state_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_ETHERTYPE = 3'd1,
        ERR_IP_HDR    = 3'd2,
        ERR_PROTO     = 3'd3,
        ERR_UDP_LEN   = 3'd4,
        ERR_TRUNC     = 3'd5
    } err_code_t;

    localparam logic [7:0]  ETH_SFD        = 8'hD5;
    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] TPID_VLAN      = 16'h8100;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    localparam int unsigned ETH_HDR_LEN  = 14;
    localparam int unsigned VLAN_TAG_LEN = 4;
    localparam int unsigned IP_HDR_LEN   = 20;
    localparam int unsigned UDP_HDR_LEN  = 8;

endpackage

// File: rtl/udp_frame_parser_preamble_detector.sv
// Counts consecutive preamble bytes and flags a qualifying start-of-frame delimiter.
module preamble_detector
    import udp_parser_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_i,
    input  logic       valid_i,
    input  logic       last_i,
    input  logic       hunt_i,
    output logic       sfd_hit_c
);

    localparam int unsigned PC_W = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(PREAMBLE_LEN);

    logic [PC_W-1:0] pc_q;

    // SFD only counts after a full preamble and never on the frame's final byte
    assign sfd_hit_c = hunt_i && valid_i && !last_i &&
                       (byte_i == ETH_SFD) && (pc_q == PC_MAX);

    // Saturating preamble counter, cleared by any non-preamble byte or frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else if (valid_i && hunt_i) begin
            if (last_i) begin
                pc_q <= '0;
            end else if (byte_i == PREAMBLE_BYTE) begin
                if (pc_q != PC_MAX) begin
                    pc_q <= pc_q + PC_W'(1);
                end
            end else begin
                pc_q <= '0;
            end
        end
    end

endmodule

// File: rtl/udp_frame_parser.sv
// Byte-serial Ethernet II / IPv4 / UDP receive parser forwarding only the UDP payload.
module udp_frame_parser
    import udp_parser_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter bit          VLAN_EN      = 1'b1,
    parameter logic [15:0] DST_PORT     = 16'h0000,
    parameter int unsigned LEN_W        = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    output logic        m_tlast,
    output logic        hdr_valid,
    output logic [15:0] udp_src_port,
    output logic [15:0] udp_dst_port,
    output logic [31:0] ip_src_addr,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        drop
);

    parser_state_t    state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] rem_q;
    logic             vlan_q;
    logic [7:0]       ety_hi_q;
    logic [31:0]      ip_src_q;
    logic [47:0]      udp_hdr_q;
    logic             sfd_hit_c;
    logic [LEN_W-1:0] ety_lo_idx_c;
    logic [15:0]      udp_len_c;
    logic [15:0]      udp_dst_c;
    logic [LEN_W-1:0] payload_len_c;

    preamble_detector #(
        .PREAMBLE_LEN (PREAMBLE_LEN)
    ) u_preamble (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_i    (s_tdata),
        .valid_i   (s_tvalid),
        .last_i    (s_tlast),
        .hunt_i    (state_q == ST_IDLE),
        .sfd_hit_c (sfd_hit_c)
    );

    // Ethertype low byte sits four bytes later once a VLAN tag has been seen
    assign ety_lo_idx_c  = vlan_q ? LEN_W'(ETH_HDR_LEN + VLAN_TAG_LEN - 1)
                                  : LEN_W'(ETH_HDR_LEN - 1);
    assign udp_dst_c     = udp_hdr_q[31:16];
    assign udp_len_c     = udp_hdr_q[15:0];
    assign payload_len_c = LEN_W'(udp_len_c - 16'(UDP_HDR_LEN));

    // Header walk, field validation and payload forwarding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            vlan_q       <= 1'b0;
            ety_hi_q     <= '0;
            ip_src_q     <= '0;
            udp_hdr_q    <= '0;
            m_tdata      <= '0;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            hdr_valid    <= 1'b0;
            udp_src_port <= '0;
            udp_dst_port <= '0;
            ip_src_addr  <= '0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            drop         <= 1'b0;
        end else begin
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            hdr_valid <= 1'b0;
            err       <= 1'b0;
            drop      <= 1'b0;
            if (s_tvalid) begin
                case (state_q)
                    ST_IDLE: begin
                        if (sfd_hit_c) begin
                            state_q <= ST_ETH;
                            cnt_q   <= '0;
                            vlan_q  <= 1'b0;
                        end
                    end
                    ST_ETH: begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (s_tlast) begin
                            err      <= 1'b1;
                            err_code <= ERR_TRUNC;
                            state_q  <= ST_IDLE;
                        end else if (cnt_q == ety_lo_idx_c - LEN_W'(1)) begin
                            ety_hi_q <= s_tdata;
                        end else if (cnt_q == ety_lo_idx_c) begin
                            if (VLAN_EN && !vlan_q && ({ety_hi_q, s_tdata} == TPID_VLAN)) begin
                                vlan_q <= 1'b1;
                            end else if ({ety_hi_q, s_tdata} == ETHERTYPE_IPV4) begin
                                state_q <= ST_IP;
                                cnt_q   <= '0;
                            end else begin
                                err      <= 1'b1;
                                err_code <= ERR_ETHERTYPE;
                                state_q  <= ST_DRAIN;
                            end
                        end
                    end
                    ST_IP: begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (s_tlast) begin
                            err      <= 1'b1;
                            err_code <= ERR_TRUNC;
                            state_q  <= ST_IDLE;
                        end else if ((cnt_q == LEN_W'(0)) && (s_tdata != IP_VER_IHL)) begin
                            err      <= 1'b1;
                            err_code <= ERR_IP_HDR;
                            state_q  <= ST_DRAIN;
                        end else if ((cnt_q == LEN_W'(9)) && (s_tdata != IP_PROTO_UDP)) begin
                            err      <= 1'b1;
                            err_code <= ERR_PROTO;
                            state_q  <= ST_DRAIN;
                        end else begin
                            if ((cnt_q >= LEN_W'(12)) && (cnt_q <= LEN_W'(15))) begin
                                ip_src_q <= {ip_src_q[23:0], s_tdata};
                            end
                            if (cnt_q == LEN_W'(IP_HDR_LEN - 1)) begin
                                state_q <= ST_UDP;
                                cnt_q   <= '0;
                            end
                        end
                    end
                    ST_UDP: begin
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (s_tlast) begin
                            err      <= 1'b1;
                            err_code <= ERR_TRUNC;
                            state_q  <= ST_IDLE;
                        end else if (cnt_q < LEN_W'(6)) begin
                            udp_hdr_q <= {udp_hdr_q[39:0], s_tdata};
                        end else if (cnt_q == LEN_W'(UDP_HDR_LEN - 1)) begin
                            if (udp_len_c < 16'(UDP_HDR_LEN)) begin
                                err      <= 1'b1;
                                err_code <= ERR_UDP_LEN;
                                state_q  <= ST_DRAIN;
                            end else if ((DST_PORT != 16'h0000) && (udp_dst_c != DST_PORT)) begin
                                drop    <= 1'b1;
                                state_q <= ST_DRAIN;
                            end else begin
                                hdr_valid    <= 1'b1;
                                udp_src_port <= udp_hdr_q[47:32];
                                udp_dst_port <= udp_dst_c;
                                ip_src_addr  <= ip_src_q;
                                rem_q        <= payload_len_c;
                                state_q      <= (payload_len_c == '0) ? ST_DRAIN : ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        m_tvalid <= 1'b1;
                        m_tdata  <= s_tdata;
                        rem_q    <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            m_tlast <= 1'b1;
                            state_q <= s_tlast ? ST_IDLE : ST_DRAIN;
                        end else if (s_tlast) begin
                            m_tlast  <= 1'b1;
                            err      <= 1'b1;
                            err_code <= ERR_TRUNC;
                            state_q  <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        if (s_tlast) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp_frame_parser.sv
// Randomised frame-level bench for udp_frame_parser: three configurations share one stream.
module tb_udp_frame_parser;

    localparam int unsigned PL = 7;

    typedef struct packed {
        logic        mv;
        logic [7:0]  md;
        logic        ml;
        logic        hv;
        logic        er;
        logic [2:0]  ec;
        logic        dr;
        logic [15:0] src;
        logic [15:0] dst;
        logic [31:0] ip;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;

    logic [7:0]  m_tdata      [3];
    logic        m_tvalid     [3];
    logic        m_tlast      [3];
    logic        hdr_valid    [3];
    logic [15:0] udp_src_port [3];
    logic [15:0] udp_dst_port [3];
    logic [31:0] ip_src_addr  [3];
    logic        err          [3];
    logic [2:0]  err_code     [3];
    logic        drop         [3];

    // instance 0: VLAN on, all ports; 1: VLAN off; 2: VLAN on, port filter 0x3039
    bit          vlan_cfg [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] port_cfg [3] = '{16'h0000, 16'h0000, 16'h3039};

    udp_frame_parser #(.PREAMBLE_LEN(PL), .VLAN_EN(1'b1), .DST_PORT(16'h0000), .LEN_W(11)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tlast(m_tlast[0]), .hdr_valid(hdr_valid[0]),
        .udp_src_port(udp_src_port[0]), .udp_dst_port(udp_dst_port[0]), .ip_src_addr(ip_src_addr[0]),
        .err(err[0]), .err_code(err_code[0]), .drop(drop[0]));

    udp_frame_parser #(.PREAMBLE_LEN(PL), .VLAN_EN(1'b0), .DST_PORT(16'h0000), .LEN_W(11)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tlast(m_tlast[1]), .hdr_valid(hdr_valid[1]),
        .udp_src_port(udp_src_port[1]), .udp_dst_port(udp_dst_port[1]), .ip_src_addr(ip_src_addr[1]),
        .err(err[1]), .err_code(err_code[1]), .drop(drop[1]));

    udp_frame_parser #(.PREAMBLE_LEN(PL), .VLAN_EN(1'b1), .DST_PORT(16'h3039), .LEN_W(11)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .m_tdata(m_tdata[2]), .m_tvalid(m_tvalid[2]), .m_tlast(m_tlast[2]), .hdr_valid(hdr_valid[2]),
        .udp_src_port(udp_src_port[2]), .udp_dst_port(udp_dst_port[2]), .ip_src_addr(ip_src_addr[2]),
        .err(err[2]), .err_code(err_code[2]), .drop(drop[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] fb [$];
    logic [7:0] pl [$];
    int         pay_start;
    exp_t       mev [3][256];
    exp_t [2:0] expq [$];

    logic [15:0] hsrc [3];
    logic [15:0] hdst [3];
    logic [31:0] hip  [3];
    logic [2:0]  hec  [3];

    int         beats [3];
    int         hdrs  [3];
    int         errs  [3];
    int         drops [3];
    logic [7:0] last_md [3];

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [7:0] gb(input int i);
        return (i < fb.size()) ? fb[i] : 8'h00;
    endfunction

    // Frame-level reference: what each accepted byte index must produce for instance k
    task automatic model(input int k, input int last);
        int cnt, sfd, h, et_idx, eth_len, ip, udp, he, fe, rem, i;
        logic [2:0]  fc;
        logic [15:0] et, ulen, dp;
        for (int j = 0; j <= last; j++) mev[k][j] = '0;
        sfd = -1;
        cnt = 0;
        fc  = 3'd0;
        for (int j = 0; j <= last; j++) begin
            if (fb[j] == 8'h55) cnt = (cnt < int'(PL)) ? cnt + 1 : int'(PL);
            else if (fb[j] == 8'hD5 && cnt == int'(PL) && j < last) begin sfd = j; break; end
            else cnt = 0;
        end
        if (sfd < 0) return;
        h = sfd + 1;
        eth_len = 14;
        et_idx = h + 13;
        et = {gb(h + 12), gb(h + 13)};
        if (vlan_cfg[k] && et == 16'h8100) begin
            eth_len = 18;
            et_idx = h + 17;
            et = {gb(h + 16), gb(h + 17)};
        end
        ip   = h + eth_len;
        udp  = ip + 20;
        he   = udp + 7;
        ulen = {gb(udp + 4), gb(udp + 5)};
        dp   = {gb(udp + 2), gb(udp + 3)};
        fe   = -1;
        if (et != 16'h0800)          begin fe = et_idx; fc = 3'd1; end
        else if (gb(ip) != 8'h45)    begin fe = ip;     fc = 3'd2; end
        else if (gb(ip + 9) != 8'h11) begin fe = ip + 9; fc = 3'd3; end
        else if (ulen < 16'd8)       begin fe = he;     fc = 3'd4; end
        if (last <= ((fe >= 0) ? fe : he)) begin
            mev[k][last].er = 1'b1;
            mev[k][last].ec = 3'd5;
            return;
        end
        if (fe >= 0) begin
            mev[k][fe].er = 1'b1;
            mev[k][fe].ec = fc;
            return;
        end
        if (port_cfg[k] != 16'h0000 && dp != port_cfg[k]) begin
            mev[k][he].dr = 1'b1;
            return;
        end
        mev[k][he].hv  = 1'b1;
        mev[k][he].src = {gb(udp), gb(udp + 1)};
        mev[k][he].dst = dp;
        mev[k][he].ip  = {gb(ip + 12), gb(ip + 13), gb(ip + 14), gb(ip + 15)};
        rem = int'(ulen) - 8;
        for (int j = 0; j < rem; j++) begin
            i = he + 1 + j;
            if (i > last) break;
            mev[k][i].mv = 1'b1;
            mev[k][i].md = fb[i];
            if (j == rem - 1) mev[k][i].ml = 1'b1;
            else if (i == last) begin
                mev[k][i].ml = 1'b1;
                mev[k][i].er = 1'b1;
                mev[k][i].ec = 3'd5;
            end
        end
    endtask

    // One clock of stimulus; queues what every instance must show after the next edge
    task automatic step(input bit v, input logic [7:0] d, input bit l, input int idx, input bit rst);
        exp_t [2:0] e;
        exp_t m;
        @(negedge clk);
        rst_n    = !rst;
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                hsrc[k] = '0; hdst[k] = '0; hip[k] = '0; hec[k] = '0;
                e[k] = '0;
            end else begin
                m = (v && idx >= 0) ? mev[k][idx] : '0;
                if (m.hv) begin hsrc[k] = m.src; hdst[k] = m.dst; hip[k] = m.ip; end
                if (m.er) hec[k] = m.ec;
                e[k]     = m;
                e[k].src = hsrc[k];
                e[k].dst = hdst[k];
                e[k].ip  = hip[k];
                e[k].ec  = hec[k];
            end
        end
        expq.push_back(e);
    endtask

    task automatic build(input int pre_n, input bit vlan, input logic [15:0] etype, input logic [7:0] vi,
                         input logic [7:0] proto, input logic [15:0] dst, input logic [15:0] ulen,
                         input int tail_n);
        fb.delete();
        repeat (pre_n) fb.push_back(8'h55);
        fb.push_back(8'hD5);
        repeat (12) fb.push_back(8'($urandom));
        if (vlan) begin
            fb.push_back(8'h81); fb.push_back(8'h00);
            fb.push_back(8'($urandom)); fb.push_back(8'($urandom));
        end
        fb.push_back(etype[15:8]); fb.push_back(etype[7:0]);
        fb.push_back(vi);
        repeat (8) fb.push_back(8'($urandom));
        fb.push_back(proto);
        repeat (10) fb.push_back(8'($urandom));
        repeat (2) fb.push_back(8'($urandom));
        fb.push_back(dst[15:8]); fb.push_back(dst[7:0]);
        fb.push_back(ulen[15:8]); fb.push_back(ulen[7:0]);
        repeat (2) fb.push_back(8'($urandom));
        pay_start = fb.size();
        foreach (pl[j]) fb.push_back(pl[j]);
        repeat (tail_n) fb.push_back(8'($urandom));
    endtask

    task automatic send(input int keep, input int abort_at);
        for (int k = 0; k < 3; k++) model(k, keep - 1);
        for (int i = 0; i < keep; i++) begin
            if (i == abort_at) begin
                step(1'b0, 8'h00, 1'b0, -1, 1'b1);
                step(1'b0, 8'h00, 1'b0, -1, 1'b1);
                step(1'b0, 8'h00, 1'b0, -1, 1'b0);
                return;
            end
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) step(1'b0, 8'($urandom), 1'($urandom), -1, 1'b0);
            step(1'b1, fb[i], i == keep - 1, i, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, -1, 1'b0);
        step(1'b0, 8'h00, 1'b0, -1, 1'b0);
    endtask

    task automatic clr_cnt();
        for (int k = 0; k < 3; k++) begin
            beats[k] = 0; hdrs[k] = 0; errs[k] = 0; drops[k] = 0; last_md[k] = '0;
        end
    endtask

    task automatic base_payload();
        pl.delete();
        pl.push_back(8'hDE); pl.push_back(8'hAD); pl.push_back(8'hBE); pl.push_back(8'hEF);
    endtask

    // Per-cycle comparison of every instance against the queued expectation
    initial begin
        exp_t [2:0] e;
        exp_t act;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    act = '{mv: m_tvalid[k], md: (m_tvalid[k] ? m_tdata[k] : 8'h00), ml: m_tlast[k],
                            hv: hdr_valid[k], er: err[k], ec: err_code[k], dr: drop[k],
                            src: udp_src_port[k], dst: udp_dst_port[k], ip: ip_src_addr[k]};
                    checks++;
                    if (act !== e[k]) begin
                        errors++;
                        $display("FAIL outputs inst%0d t=%0t: got %h expected %h", k, $time, act, e[k]);
                    end
                    if (act.mv) begin beats[k]++; last_md[k] = act.md; end
                    if (act.hv) hdrs[k]++;
                    if (act.er) errs[k]++;
                    if (act.dr) drops[k]++;
                end
            end
        end
    end

    initial begin
        int pre_n, plen, keep, abort_at, tail_n;
        bit vlan;
        logic [15:0] etype, dst, ulen;
        logic [7:0] vi, proto;

        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
        clr_cnt();
        repeat (3) step(1'b0, 8'h00, 1'b0, -1, 1'b1);
        step(1'b0, 8'h00, 1'b0, -1, 1'b0);
        @(posedge clk); #2;
        chk("reset_hdr_valid", int'(hdr_valid[0]), 0);
        chk("reset_err_code", int'(err_code[0]), 0);

        // Baseline frame: 4-byte payload to port 0x3039
        base_payload(); clr_cnt();
        build(7, 1'b0, 16'h0800, 8'h45, 8'h11, 16'h3039, 16'd12, 4);
        send(fb.size(), -1);
        chk("basic_hdr", hdrs[0], 1);
        chk("basic_beats", beats[0], 4);
        chk("basic_last_data", int'(last_md[0]), 'hEF);
        chk("basic_dst_port", int'(udp_dst_port[0]), 'h3039);
        chk("basic_err", errs[0], 0);
        chk("basic_filter_pass", hdrs[2], 1);

        // VLAN-tagged copy
        base_payload(); clr_cnt();
        build(7, 1'b1, 16'h0800, 8'h45, 8'h11, 16'h3039, 16'd12, 4);
        send(fb.size(), -1);
        chk("vlan_beats", beats[0], 4);
        chk("vlan_last_data", int'(last_md[0]), 'hEF);
        chk("novlan_err_code", int'(err_code[1]), 1);
        chk("novlan_beats", beats[1], 0);

        // Short preamble ignored, long preamble accepted
        base_payload(); clr_cnt();
        build(6, 1'b0, 16'h0800, 8'h45, 8'h11, 16'h3039, 16'd12, 4);
        send(fb.size(), -1);
        chk("short_pre_hdr", hdrs[0], 0);
        clr_cnt();
        build(9, 1'b0, 16'h0800, 8'h45, 8'h11, 16'h3039, 16'd12, 4);
        send(fb.size(), -1);
        chk("long_pre_hdr", hdrs[0], 1);

        // TCP protocol, then recovery
        base_payload(); clr_cnt();
        build(7, 1'b0, 16'h0800, 8'h45, 8'h06, 16'h3039, 16'd12, 4);
        send(fb.size(), -1);
        chk("proto_err_code", int'(err_code[0]), 3);
        chk("proto_beats", beats[0], 0);
        clr_cnt();
        build(7, 1'b0, 16'h0800, 8'h45, 8'h11, 16'h3039, 16'd12, 4);
        send(fb.size(), -1);
        chk("recover_beats", beats[0], 4);

        // Port filter drop
        base_payload(); clr_cnt();
        build(7, 1'b0, 16'h0800, 8'h45, 8'h11, 16'h0050, 16'd12, 4);
        send(fb.size(), -1);
        chk("filter_drop", drops[2], 1);
        chk("filter_hdr", hdrs[2], 0);
        chk("filter_beats", beats[2], 0);
        chk("nofilter_hdr", hdrs[0], 1);

        // Truncated payload
        base_payload(); clr_cnt();
        build(7, 1'b0, 16'h0800, 8'h45, 8'h11, 16'h3039, 16'd12, 4);
        send(pay_start + 2, -1);
        chk("trunc_beats", beats[0], 2);
        chk("trunc_last_data", int'(last_md[0]), 'hAD);
        chk("trunc_err_code", int'(err_code[0]), 5);

        // Reset mid-payload, then a clean frame
        base_payload(); clr_cnt();
        build(7, 1'b0, 16'h0800, 8'h45, 8'h11, 16'h3039, 16'd12, 4);
        send(fb.size(), pay_start + 2);
        chk("abort_beats", beats[0], 2);
        chk("abort_dst_cleared", int'(udp_dst_port[0]), 0);
        clr_cnt();
        build(7, 1'b0, 16'h0800, 8'h45, 8'h11, 16'h3039, 16'd12, 4);
        send(fb.size(), -1);
        chk("post_abort_beats", beats[0], 4);

        // Randomised frames
        for (int f = 0; f < 150; f++) begin
            pre_n = $urandom_range(5, 10);
            vlan  = ($urandom_range(0, 2) == 0);
            etype = ($urandom_range(0, 11) == 0) ? 16'($urandom) : 16'h0800;
            vi    = ($urandom_range(0, 14) == 0) ? 8'h46 : 8'h45;
            proto = ($urandom_range(0, 11) == 0) ? 8'h06 : 8'h11;
            case ($urandom_range(0, 2))
                0:       dst = 16'h3039;
                1:       dst = 16'h0050;
                default: dst = 16'($urandom);
            endcase
            plen = $urandom_range(0, 30);
            pl.delete();
            repeat (plen) pl.push_back(8'($urandom));
            ulen = 16'(plen + 8);
            if ($urandom_range(0, 11) == 0) ulen = 16'($urandom_range(0, 7));
            else if ($urandom_range(0, 9) == 0) ulen = 16'(plen + 8 + $urandom_range(1, 10));
            tail_n = $urandom_range(4, 10);
            build(pre_n, vlan, etype, vi, proto, dst, ulen, tail_n);
            keep = ($urandom_range(0, 7) == 0) ? $urandom_range(pre_n + 2, fb.size()) : fb.size();
            abort_at = ($urandom_range(0, 19) == 0) ? $urandom_range(pre_n + 1, keep - 1) : -1;
            send(keep, abort_at);
        end

        @(posedge clk); #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_frame_parser.md
Name: udp_frame_parser

Overview:
- Byte-serial Ethernet II / IPv4 / UDP receive parser.
- Locks to preamble+SFD, walks the Ethernet (optional 802.1Q), IPv4 and UDP headers, and validates key fields.
- Forwards only the UDP payload as a byte stream, with extracted header fields and error/drop reporting.
- Sits between the MAC byte stream and the market-data message decoder; parametrised successor of the preamble-only parser.

Parameters:
- PREAMBLE_LEN, 7, minimum consecutive 0x55 bytes required before 0xD5 SFD.
- VLAN_EN, 1, 1 = accept one 802.1Q tag (TPID 0x8100, 4 extra bytes); 0 = TPID 0x8100 is an ethertype error.
- DST_PORT, 16'h0000, UDP destination-port filter; 0 = accept all ports.
- LEN_W, 11, width of the byte/length counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- s_tdata  in  8  input byte
- s_tvalid  in  1  byte qualifier; no backpressure
- s_tlast  in  1  last byte of frame (after FCS)
- m_tdata  out  8  payload byte
- m_tvalid  out  1  payload byte valid
- m_tlast  out  1  last payload byte of datagram
- hdr_valid  out  1  one-cycle pulse: headers accepted, payload follows
- udp_src_port  out  16  held from hdr_valid until next hdr_valid
- udp_dst_port  out  16  as above
- ip_src_addr  out  32  as above
- err  out  1  one-cycle error pulse
- err_code  out  3  1=ethertype, 2=IP version/IHL, 3=protocol!=17, 4=UDP length<8, 5=truncated; held until next err
- drop  out  1  one-cycle pulse: valid datagram discarded by port filter

Behaviour:
- Reset: state IDLE; all counters 0; every output 0.
- Reset is async; a frame in flight is abandoned, with no m_tlast and no err.
- All outputs are registered. m_tdata/m_tvalid/m_tlast lag the accepted input byte by 1 cycle.
- Cycles with s_tvalid=0 are ignored in every state: no state change, no counter change.
- FSM states: IDLE, ETH, IP, UDP, PAYLOAD, DRAIN.
- IDLE (preamble count pc):
  - 0x55: pc = min(pc+1, PREAMBLE_LEN); surplus preamble is tolerated.
  - 0xD5 with pc==PREAMBLE_LEN: go to ETH, byte count cnt=0.
  - Any other byte, or s_tlast: pc=0.
- ETH: 14 bytes (MAC addresses ignored).
  - Ethertype taken at bytes 12-13.
  - If 0x8100 and VLAN_EN: skip 4 more bytes and read the inner ethertype at bytes 16-17.
  - Ethertype != 0x0800: err code 1, go to DRAIN.
- IP: 20 bytes.
  - Byte 0 must equal 0x45, else code 2.
  - Byte 9 must equal 0x11, else code 3.
  - Bytes 12-15 captured into a shadow register for ip_src_addr.
  - Header checksum is not checked.
  - Error is flagged at the offending byte; go to DRAIN.
- UDP: 8 bytes; ports and length captured into shadow registers.
  - At byte 7: length<8 gives code 4, go to DRAIN.
  - Otherwise, if DST_PORT!=0 and dst!=DST_PORT: pulse drop, go to DRAIN.
  - Otherwise: copy shadows to the outputs, pulse hdr_valid, remaining=length-8.
  - remaining==0 goes to DRAIN.
- PAYLOAD: forward each byte and decrement remaining.
  - m_tlast is asserted when remaining==1; then go to DRAIN, which discards Ethernet padding and FCS.
- DRAIN: discard bytes until s_tlast, then go to IDLE with pc=0.
- s_tlast in ETH/IP/UDP: err code 5, go to IDLE (takes priority over field errors on the same byte).
- s_tlast in PAYLOAD with remaining>1: forward the byte with m_tlast=1, err code 5, go to IDLE.
- Byte carrying s_tlast in DRAIN, or with the last payload byte: go straight to IDLE.
- err and hdr_valid never pulse in the same cycle.
- Counters use LEN_W bits; UDP length above 2^LEN_W-1+8 is unsupported.

Decomposition:
- Package udp_parser_pkg holds:
  - parser_state_t enum.
  - err_code_t enum.
  - Constants: ETH_SFD=8'hD5, PREAMBLE_BYTE=8'h55, ETHERTYPE_IPV4=16'h0800, TPID_VLAN=16'h8100, IP_VER_IHL=8'h45, IP_PROTO_UDP=8'h11, ETH_HDR_LEN=14, IP_HDR_LEN=20, UDP_HDR_LEN=8.
- Optional sub-module preamble_detector: owns pc, outputs sfd_hit.
- Everything else stays in one FSM module.

Test Plan:
- 7x0x55, 0xD5, IPv4/UDP header dst 0x3039 len 12, 4 payload bytes DE AD BE EF, 4 FCS bytes, tlast → hdr_valid once; 4 m_tvalid beats, m_tlast on 0xEF; udp_dst_port=0x3039; no err.
- Same frame with VLAN tag, VLAN_EN=1 → identical payload output. With VLAN_EN=0 → err code 1, no m_tvalid.
- 6x0x55 then 0xD5, then a valid frame → ignored. 9x0x55 then 0xD5 → accepted.
- IP protocol 0x06 → err code 3 at IP byte 9; remaining bytes silent until tlast; next valid frame parses normally.
- DST_PORT=0x3039, frame to 0x0050 → drop pulse, no hdr_valid, no m_tvalid.
- tlast on 2nd of 4 payload bytes → 2 beats, m_tlast on the 2nd, err code 5. rst_n low mid-payload → all outputs 0 next cycle; a following frame parses normally.
